// File: rtl/ascii_to_serial_if.sv
// rtl/ascii_to_serial_if.sv - producer-side byte/strobe handshake for the serial transmitter
interface ascii_to_serial_if;
  logic [7:0] in;
  logic       in_valid;
  logic       enter;
  logic       tab;
  logic       backspace;
  logic       in_ready;

  modport master (
    output in,
    output in_valid,
    output enter,
    output tab,
    output backspace,
    input  in_ready
  );

  modport slave (
    input  in,
    input  in_valid,
    input  enter,
    input  tab,
    input  backspace,
    output in_ready
  );
endinterface

// File: rtl/ascii_to_serial.sv
// rtl/ascii_to_serial.sv - FIFO-buffered start/8N/stop serialiser; ASCII_TX_PARITY_EN adds an odd-parity bit
module ascii_to_serial #(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  ascii_to_serial_if.slave  bus,
  output logic              data,
  output logic              busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST_TICK  = TW'(BIT_CYCLES - 1);

`ifdef ASCII_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            data_q, data_d;
`ifdef ASCII_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [7:0]      push_byte;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            tick_last;
  logic            fifo_nonempty;
  logic [7:0]      head_byte;

  // Strobes outrank the character; a null character is not a request at all.
  always_comb begin
    push_byte = 8'h00;
    push_req  = 1'b0;
    if (bus.enter) begin
      push_byte = 8'd13;
      push_req  = 1'b1;
    end else if (bus.tab) begin
      push_byte = 8'd9;
      push_req  = 1'b1;
    end else if (bus.backspace) begin
      push_byte = 8'd8;
      push_req  = 1'b1;
    end else if (bus.in_valid && (bus.in != 8'h00)) begin
      push_byte = bus.in;
      push_req  = 1'b1;
    end
  end

  assign push          = push_req & in_ready_q;
  assign tick_last     = (timer_q == LAST_TICK);
  assign fifo_nonempty = (count_q != '0);
  assign head_byte     = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    pop      = 1'b0;
    timer_d  = tick_last ? '0 : timer_q + TW'(1);
`ifdef ASCII_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head_byte;
`ifdef ASCII_TX_PARITY_EN
          parity_d = ~^head_byte;
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick_last) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef ASCII_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef ASCII_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_last) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (tick_last) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head_byte;
`ifdef ASCII_TX_PARITY_EN
            parity_d = ~^head_byte;
`endif
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is derived from the next state so the output stays a flop.
  always_comb begin
    data_d = 1'b1;
    case (state_d)
      ST_START:  data_d = 1'b0;
      ST_DATA:   data_d = shift_d[0];
`ifdef ASCII_TX_PARITY_EN
      ST_PARITY: data_d = parity_d;
`endif
      default:   data_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    in_ready_d = (count_d != FULL_COUNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      timer_q    <= '0;
      bit_q      <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      data_q     <= 1'b1;
`ifdef ASCII_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      data_q     <= data_d;
`ifdef ASCII_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  assign bus.in_ready = in_ready_q;
  assign data         = data_q;
  assign busy         = (state_q != ST_IDLE) | fifo_nonempty;

endmodule
